capture_mem_arbiter: RTL

//  Shares the single 128-bit memory command port between the capture write path and the trace readback path.

---
 rtl/capture_mem_arbiter.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/capture_mem_arbiter.sv
// capture_mem_arbiter: packs capture packets into memory lines, queues them in a write FIFO and
// shares the memory command port between those writes and single-line readback reads.
module capture_mem_arbiter #(
    parameter int PACKET_WIDTH = 32,
    parameter int LINE_WIDTH   = 128,
    parameter int ADDR_WIDTH   = 27,
    parameter int WFIFO_DEPTH  = 8,
    parameter int WR_BURST_MAX = 4
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    flush,
    input  logic [PACKET_WIDTH-1:0] samplePacket,
    input  logic                    write_enable,
    input  logic [31:0]             sample_number,
    output logic                    pageFull,
    input  logic                    read_req,
    input  logic [ADDR_WIDTH-1:0]   read_sample_address,
    output logic                    read_allowed,
    output logic                    has_return_data,
    output logic [LINE_WIDTH-1:0]   return_data,
    input  logic                    get_return_data,
    output logic                    mem_cmd_valid,
    input  logic                    mem_cmd_ready,
    output logic                    mem_cmd_write,
    output logic [ADDR_WIDTH-1:0]   mem_cmd_addr,
    output logic [LINE_WIDTH-1:0]   mem_wdata,
    input  logic                    mem_rd_valid,
    input  logic [LINE_WIDTH-1:0]   mem_rd_data,
    output logic                    overflow,
    output logic                    busy
);
    localparam int NSLOT = LINE_WIDTH / PACKET_WIDTH;
    localparam int PW = $clog2(WFIFO_DEPTH);
    localparam int SW = $clog2(WR_BURST_MAX + 1);
    localparam logic [PW:0] FULL_LVL = (PW+1)'(WFIFO_DEPTH);
    localparam logic [PW:0] PF_LVL = (PW+1)'(WFIFO_DEPTH - 1);
    localparam logic [SW-1:0] BURST = SW'(WR_BURST_MAX);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WR = 2'd1;
    localparam logic [1:0] S_RD = 2'd2;
    localparam logic [1:0] S_WAIT = 2'd3;

    logic [LINE_WIDTH-1:0] r_line;
    logic [NSLOT-1:0] r_fill;
    logic [ADDR_WIDTH-1:0] r_line_addr;
    logic [ADDR_WIDTH+LINE_WIDTH-1:0] r_mem [WFIFO_DEPTH];
    logic [PW-1:0] r_wp, r_rp;
    logic [PW:0] r_count;
    logic r_page_full, r_overflow, r_has;
    logic [1:0] r_state;
    logic [SW-1:0] r_streak;
    logic [ADDR_WIDTH-1:0] r_rd_addr;
    logic [LINE_WIDTH-1:0] r_ret;

    logic [1:0] w_slot;
    logic [LINE_WIDTH-1:0] w_line;
    logic [NSLOT-1:0] w_fill;
    logic [ADDR_WIDTH-1:0] w_addr;
    logic w_commit, w_full, w_push, w_pop, w_rd_pend, w_go_wr, w_go_rd, w_unused;
    logic [PW:0] w_count_n;
    logic [ADDR_WIDTH+LINE_WIDTH-1:0] w_head;

    assign w_slot = sample_number[1:0];
    assign w_unused = &{1'b0, sample_number[31:ADDR_WIDTH+2]};

    always_comb begin
        w_line = r_line;
        w_fill = r_fill;
        for (int i = 0; i < NSLOT; i++)
            if (write_enable && w_slot == 2'(i)) begin
                w_line[i*PACKET_WIDTH +: PACKET_WIDTH] = samplePacket;
                w_fill[i] = 1'b1;
            end
    end

    // A same-cycle flush sees the incoming packet already merged into w_line/w_fill.
    assign w_commit = (write_enable && w_slot == 2'(NSLOT-1)) || (flush && |w_fill);
    assign w_addr = write_enable ? sample_number[ADDR_WIDTH+1:2] : r_line_addr;
    assign w_full = r_count == FULL_LVL;
    assign w_push = w_commit && !w_full;
    assign w_pop = r_state == S_WR && mem_cmd_ready;
    assign w_count_n = r_count + (PW+1)'(w_push) - (PW+1)'(w_pop);
    assign w_head = r_mem[r_rp];
    assign w_rd_pend = read_req && !r_has;
    assign w_go_wr = r_count != '0 && (!w_rd_pend || r_streak < BURST);
    assign w_go_rd = read_req && !r_has;

    always_ff @(posedge clk)
        if (w_push) r_mem[r_wp] <= {w_addr, w_line};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_line <= '0;
            r_fill <= '0;
            r_line_addr <= '0;
            r_wp <= '0;
            r_rp <= '0;
            r_count <= '0;
            r_page_full <= 1'b0;
            r_overflow <= 1'b0;
            r_has <= 1'b0;
            r_state <= S_IDLE;
            r_streak <= '0;
            r_rd_addr <= '0;
            r_ret <= '0;
        end else begin
            r_line <= w_commit ? '0 : w_line;
            r_fill <= w_commit ? '0 : w_fill;
            r_line_addr <= w_addr;
            r_wp <= w_push ? r_wp + 1'b1 : r_wp;
            r_rp <= w_pop ? r_rp + 1'b1 : r_rp;
            r_count <= w_count_n;
            r_page_full <= w_count_n >= PF_LVL;
            r_overflow <= r_overflow || (w_commit && w_full);
            if (r_state == S_WAIT && mem_rd_valid) begin
                r_ret <= mem_rd_data;
                r_has <= 1'b1;
            end else if (get_return_data) r_has <= 1'b0;
            if (!read_req || (r_state == S_RD && mem_cmd_ready)) r_streak <= '0;
            else if (w_pop && r_streak < BURST) r_streak <= r_streak + 1'b1;
            if (r_state == S_IDLE && !w_go_wr && w_go_rd) r_rd_addr <= read_sample_address;
            case (r_state)
                S_IDLE: r_state <= w_go_wr ? S_WR : w_go_rd ? S_RD : S_IDLE;
                S_WR: r_state <= mem_cmd_ready ? S_IDLE : S_WR;
                S_RD: r_state <= mem_cmd_ready ? S_WAIT : S_RD;
                default: r_state <= mem_rd_valid ? S_IDLE : S_WAIT;
            endcase
        end
    end

    assign pageFull = r_page_full;
    assign overflow = r_overflow;
    assign has_return_data = r_has;
    assign return_data = r_ret;
    assign mem_cmd_valid = r_state == S_WR || r_state == S_RD;
    assign mem_cmd_write = r_state == S_WR;
    assign mem_cmd_addr = r_state == S_WR ? w_head[ADDR_WIDTH+LINE_WIDTH-1:LINE_WIDTH] :
                          r_state == S_RD ? r_rd_addr : '0;
    assign mem_wdata = r_state == S_WR ? w_head[LINE_WIDTH-1:0] : '0;
    assign read_allowed = r_state == S_RD && mem_cmd_ready;
    assign busy = r_count != '0 || |r_fill || r_state == S_RD || r_state == S_WAIT;
endmodule
